// File: rtl/ex_div_seq_if.sv
// Handshake bundle between the EX stage and the divide sequencer.
// The EX stage drives the request side (master); the sequencer drives stall/done/result (slave).
interface ex_div_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [1:0]            op_i;
    logic [DATA_WIDTH-1:0] rs1_i;
    logic [DATA_WIDTH-1:0] rs2_i;
    logic                  flush_i;
    logic                  stall_o;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] result_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, flush_i,
        input  stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, flush_i,
        output stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/ex_div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring divide, one quotient bit per cycle.
// Optional EX_DIV_FAST_PATH_EN: finish in one cycle when the divisor magnitude exceeds the dividend.
module ex_div_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    ex_div_seq_if.slave   bus
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [W:0]     rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W-1:0]   result_q, result_d;
    logic           neg_quo_q, neg_quo_d;
    logic           neg_rem_q, neg_rem_d;
    logic           is_rem_q, is_rem_d;

    logic           is_signed, sign1, sign2;
    logic [W-1:0]   mag1, mag2;
    logic           div_zero, overflow, fast_hit, special;
    logic [W-1:0]   special_result;
    logic [W+1:0]   shifted, trial;
    logic [W-1:0]   quo_fix, rem_fix;

    // op_i[0] selects unsigned, op_i[1] selects remainder
    assign is_signed = ~bus.op_i[0];
    assign sign1     = is_signed & bus.rs1_i[W-1];
    assign sign2     = is_signed & bus.rs2_i[W-1];
    assign mag1      = sign1 ? -bus.rs1_i : bus.rs1_i;
    assign mag2      = sign2 ? -bus.rs2_i : bus.rs2_i;
    assign div_zero  = (bus.rs2_i == '0);
    assign overflow  = is_signed && (bus.rs1_i == {1'b1, {(W-1){1'b0}}}) && (bus.rs2_i == '1);

`ifdef EX_DIV_FAST_PATH_EN
    assign fast_hit  = (mag2 > mag1);
`else
    assign fast_hit  = 1'b0;
`endif

    assign special = div_zero | overflow | fast_hit;

    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = bus.op_i[1] ? bus.rs1_i : '1;
        end else if (overflow) begin
            special_result = bus.op_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
        end else if (fast_hit) begin
            special_result = bus.op_i[1] ? bus.rs1_i : '0;
        end
    end

    // Restoring step: the top bit of the trial difference is the borrow.
    assign shifted = {rem_q, quo_q[W-1]};
    assign trial   = shifted - {2'b00, dvs_q};
    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q[W-1:0] : rem_q[W-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    is_rem_d = bus.op_i[1];
                    if (special) begin
                        result_d = special_result;
                        state_d  = S_DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = mag1;
                        dvs_d     = mag2;
                        neg_quo_d = sign1 ^ sign2;
                        neg_rem_d = sign1;
                        cnt_d     = '0;
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (!trial[W+1]) begin
                        rem_d = trial[W:0];
                    end else begin
                        rem_d = shifted[W:0];
                    end
                    quo_d = {quo_q[W-2:0], ~trial[W+1]};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = is_rem_q ? rem_fix : quo_fix;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
        end
    end

    assign bus.stall_o  = ((state_q == S_IDLE) && bus.start_i && !bus.flush_i)
                        || (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.done_o   = (state_q == S_DONE);
    assign bus.result_o = result_q;
endmodule

// File: doc/ex_div_seq.md
# ex_div_seq

Multi-cycle integer divide sequencer for the EX stage of the 5-stage pipeline. It implements RV32M DIV/DIVU/REM/REMU with a radix-2 restoring iteration, one quotient bit per cycle. While a divide is in flight it asserts a stall that freezes IF/ID/EX. It hands the result to EX in the single cycle the stall drops, so the EX/MEM register captures it in place of the ALU result.

## Interface
- DATA_WIDTH, 32, operand/result width; only 32 is supported.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  EX holds a divide instruction; sampled only in IDLE.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i.
- rs1_i  in  32  dividend, already forwarded; sampled with start_i.
- rs2_i  in  32  divisor, already forwarded; sampled with start_i.
- flush_i  in  1  branch/jump flush of EX; aborts the operation.
- stall_o  out  1  freeze IF/ID/EX pipeline registers.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse; result_o valid.
- result_o  out  32  quotient or remainder, held until next done_o.

## Operation
- States: IDLE, CALC, FIX, DONE. Counter: 5 bits. Registers: remainder 33 bits, quotient 32 bits, divisor 32 bits, flags neg_q, neg_r, is_rem.
- Reset values: state IDLE, counter 0, all datapath registers 0, result_o 0, done_o 0, busy_o 0, stall_o 0.
- IDLE, start_i=1, flush_i=0, normal case:
  - Latch magnitudes (abs values for DIV/REM, raw values for DIVU/REMU).
  - neg_q = sign(rs1) XOR sign(rs2), signed ops only. neg_r = sign(rs1), signed ops only.
  - Go to CALC with counter=0.
- Special cases, decided in IDLE; these go directly to DONE:
  - rs2=0: quotient 0xFFFFFFFF, remainder rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- CALC, one iteration per cycle:
  - Shift {rem,quo} left by 1 and trial-subtract the divisor.
  - If non-negative, keep the difference and set the quotient LSB to 1.
  - After counter=31 go to FIX.
- FIX: negate the quotient if neg_q, negate the remainder if neg_r. Load result_o (quotient or remainder per is_rem). Go to DONE.
- DONE: done_o=1, stall_o=0. Always go to IDLE; start_i is ignored in DONE.
- stall_o = (IDLE & start_i & ~flush_i) | CALC | FIX.
- start_i is ignored in CALC/FIX/DONE. Operands are never re-sampled mid-operation.
- flush_i in any state: go to IDLE next cycle, no done_o, result_o unchanged. In IDLE, flush_i overrides start_i.
- rst in any state overrides flush_i and start_i.

## Timing
- start_i sampled in cycle t (normal case):
  - CALC occupies t+1..t+32.
  - FIX occupies t+33.
  - DONE (done_o=1) occurs in t+34.
  - stall_o is high t..t+33 and low in t+34.
- Special case: done_o in t+1, stall_o high only in t.
- result_o is registered; it is valid in the done_o cycle and stable afterwards until the next FIX or special-case load.
- A back-to-back divide can start no earlier than t+35, the first IDLE cycle after DONE.
- Reset or flush asserted in cycle k puts the block in IDLE in k+1, with stall_o=0 that cycle.

## Configuration
- EX_DIV_FAST_PATH_EN defined:
  - In IDLE, if |rs2| > |rs1| (unsigned magnitudes), take a 1-cycle path to DONE.
  - Result is quotient 0, remainder rs1, with sign unchanged.
  - Latency is the same as the special cases.
- Not defined: such operations take the full 34-cycle path. Results are bit-identical either way.

## Test plan
- DIVU rs1=100, rs2=7 at t: stall_o high t..t+33; done_o only at t+34; result_o=14. Repeat as REMU: result_o=2.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2: result_o=0xFFFFFFFD (-3). REM on the same operands: result_o=0xFFFFFFFF (-1).
- Divide by zero, DIVU rs1=0x1234, rs2=0: done_o at t+1, result_o=0xFFFFFFFF. REMU on the same operands: result_o=0x1234.
- Overflow, DIV rs1=0x80000000, rs2=0xFFFFFFFF: result_o=0x80000000 at t+1. REM on the same operands: result_o=0.
- Flush at t+10 of a DIVU:
  - IDLE at t+11; no done_o; result_o keeps its prior value.
  - A new start at t+11 completes normally at t+45.
  - rst at t+5 of another divide gives all outputs at reset values at t+6.
- DIVU rs1=5, rs2=9: with EX_DIV_FAST_PATH_EN, done_o at t+1 and result_o=0. Without the macro, done_o at t+34 and result_o=0.
